// File: rtl/split_req_pkg.sv
// Shared types and the record-derivation rule for split_req_gen.
package split_req_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int MAX_W      = 64;

    typedef logic [DEF_DATA_W-1:0] data_t;
    typedef logic [DEF_DATA_W-1:0] addr_t;

    typedef struct packed {
        data_t data;
        addr_t addr;
    } payload_t;

    typedef struct packed {
        logic     ex;
        logic     valid;
        payload_t payload;
    } req_t;

    typedef logic [MAX_W-1:0]     wide_t;
    typedef logic [2*MAX_W+1:0]   wreq_t;

    function automatic int REQ_EX_BIT(input int dw);
        return 2*dw + 1;
    endfunction

    function automatic int REQ_VALID_BIT(input int dw);
        return 2*dw;
    endfunction

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Record is built at width dw in the low bits of a wide vector so one
    // function serves every DATA_W up to MAX_W; callers truncate.
    function automatic wreq_t req_make(input wide_t c, input int align_log2,
                                       input wide_t ex_addr, input wide_t hole,
                                       input int dw = DEF_DATA_W);
        wide_t msk, amsk, cm, addr, data;
        logic  ex, vld;
        msk  = (dw >= MAX_W) ? '1 : ((wide_t'(1) << dw) - wide_t'(1));
        amsk = ~((wide_t'(1) << align_log2) - wide_t'(1));
        cm   = c & msk;
        addr = cm & amsk;
        ex   = (addr == '0) || (addr == (ex_addr & msk));
        vld  = !ex && (cm != (hole & msk));
        data = vld ? cm : '0;
        return (wreq_t'(ex) << (2*dw+1)) | (wreq_t'(vld) << (2*dw)) |
               (wreq_t'(data) << dw) | wreq_t'(addr);
    endfunction

endpackage

// File: rtl/split_req_gen_if.sv
// Merged output bus of split_req_gen: strobe/ack handshake with record and source channel.
interface split_req_gen_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              m_stb;
    logic              m_ack;
    logic [2*DATA_W+1:0] m_req;
    logic [CHW-1:0]    m_chan;

    modport master (output m_stb, m_req, m_chan, input m_ack);
    modport slave  (input m_stb, m_req, m_chan, output m_ack);
endinterface

// File: rtl/split_req_chan.sv
// One generator channel: counter, generated-record count and a single-record slot.
module split_req_chan
    import split_req_pkg::*;
#(
    parameter int              DATA_W     = 32,
    parameter int              ALIGN_LOG2 = 2,
    parameter int              EX_ADDR    = 16,
    parameter int              HOLE       = 10,
    parameter int              LIMIT      = 20,
    parameter logic [DATA_W-1:0] START    = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                grant_i,
    output logic                slot_full_o,
    output logic [2*DATA_W+1:0] slot_req_o,
    output logic                exhausted_o
);
    localparam int RW = 2*DATA_W + 2;
    localparam int GW = $clog2(LIMIT + 1);

    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]     gen_q, gen_d;
    logic              full_q, full_d;
    logic [RW-1:0]     req_q, req_d;
    logic [RW-1:0]     rec;
    logic              load;

    always_comb begin
        rec    = RW'(req_make(wide_t'(cnt_q), ALIGN_LOG2, wide_t'(EX_ADDR),
                              wide_t'(HOLE), DATA_W));
        // A granted slot may refill in the same cycle it drains.
        load   = (!full_q || grant_i) && (gen_q < GW'(LIMIT));
        cnt_d  = load ? cnt_q + DATA_W'(1) : cnt_q;
        gen_d  = load ? gen_q + GW'(1) : gen_q;
        req_d  = load ? rec : req_q;
        full_d = load || (full_q && !grant_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= START;
            gen_q  <= '0;
            full_q <= 1'b0;
            req_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            gen_q  <= gen_d;
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

    assign slot_full_o = full_q;
    assign slot_req_o  = req_q;
    assign exhausted_o = (gen_q == GW'(LIMIT)) && !full_q;

endmodule

// File: rtl/split_req_gen.sv
// Multi-channel request generator merged by a round-robin arbiter onto one registered output.
// Optional SPLIT_REQ_GEN_STATS_EN adds per-channel ex / invalid record counters.
module split_req_gen
    import split_req_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int ALIGN_LOG2 = 2,
    parameter int EX_ADDR    = 16,
    parameter int HOLE       = 10,
    parameter int LIMIT      = 20,
    parameter int STRIDE     = 0
) (
    input  logic clk,
    input  logic rst_n,
    split_req_gen_if.master m,
    output logic done
`ifdef SPLIT_REQ_GEN_STATS_EN
    ,
    output logic [NUM_CH-1:0][15:0] stat_ex,
    output logic [NUM_CH-1:0][15:0] stat_inv
`endif
);
    localparam int RW  = 2*DATA_W + 2;
    localparam int CHW = chan_w(NUM_CH);

    logic [NUM_CH-1:0]         full, exh, grant;
    logic [NUM_CH-1:0][RW-1:0] slot_req;

    logic           stb_q, done_q;
    logic [RW-1:0]  req_q;
    logic [CHW-1:0] chan_q, ptr_q, ptr_d;
    logic           gnt_vld, out_ld;
    logic [CHW-1:0] gnt_idx;
    int             idx;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        split_req_chan #(
            .DATA_W    (DATA_W),
            .ALIGN_LOG2(ALIGN_LOG2),
            .EX_ADDR   (EX_ADDR),
            .HOLE      (HOLE),
            .LIMIT     (LIMIT),
            .START     (DATA_W'(gi * STRIDE))
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .grant_i    (grant[gi]),
            .slot_full_o(full[gi]),
            .slot_req_o (slot_req[gi]),
            .exhausted_o(exh[gi])
        );
    end

    // Round-robin search starting at ptr_q.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr_q) + k) % NUM_CH;
            if (!gnt_vld && full[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = CHW'(idx);
            end
        end
        out_ld = !stb_q || m.m_ack;
        grant  = (out_ld && gnt_vld) ? (NUM_CH'(1) << gnt_idx) : '0;
        ptr_d  = (gnt_idx == CHW'(NUM_CH - 1)) ? '0 : gnt_idx + CHW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q  <= 1'b0;
            req_q  <= '0;
            chan_q <= '0;
            ptr_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (out_ld) begin
                stb_q <= gnt_vld;
                if (gnt_vld) begin
                    req_q  <= slot_req[gnt_idx];
                    chan_q <= gnt_idx;
                    ptr_q  <= ptr_d;
                end
            end
            done_q <= done;
        end
    end

    // Sticky once every channel is drained and the output register is empty.
    assign done     = done_q || (&exh && !stb_q);
    assign m.m_stb  = stb_q;
    assign m.m_req  = req_q;
    assign m.m_chan = chan_q;

`ifdef SPLIT_REQ_GEN_STATS_EN
    localparam int EXB = REQ_EX_BIT(DATA_W);
    localparam int VB  = REQ_VALID_BIT(DATA_W);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stat
        logic hs;
        assign hs = stb_q && m.m_ack && (chan_q == CHW'(gi));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stat_ex[gi]  <= '0;
                stat_inv[gi] <= '0;
            end else if (hs) begin
                if (req_q[EXB]) begin
                    if (stat_ex[gi] != 16'hFFFF) stat_ex[gi] <= stat_ex[gi] + 16'd1;
                end else if (!req_q[VB]) begin
                    if (stat_inv[gi] != 16'hFFFF) stat_inv[gi] <= stat_inv[gi] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_split_req_gen.sv
// Directed scoreboard bench: a 1-channel and a 3-channel (STRIDE=100) instance share one clock.
module tb_split_req_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic done_a, done_b;
    int   checks = 0;
    int   failures = 0;

    split_req_gen_if #(.DATA_W(32), .NUM_CH(1)) ifa ();
    split_req_gen_if #(.DATA_W(32), .NUM_CH(3)) ifb ();

`ifdef SPLIT_REQ_GEN_STATS_EN
    logic [0:0][15:0] sxa, sia;
    logic [2:0][15:0] sxb, sib;
`endif

    split_req_gen #(.NUM_CH(1)) dut_a (
        .clk  (clk),
        .rst_n(rst_a),
        .m    (ifa),
        .done (done_a)
`ifdef SPLIT_REQ_GEN_STATS_EN
        , .stat_ex(sxa), .stat_inv(sia)
`endif
    );

    split_req_gen #(.NUM_CH(3), .STRIDE(100)) dut_b (
        .clk  (clk),
        .rst_n(rst_b),
        .m    (ifb),
        .done (done_b)
`ifdef SPLIT_REQ_GEN_STATS_EN
        , .stat_ex(sxb), .stat_inv(sib)
`endif
    );

    logic [65:0] qa[$];
    logic [67:0] qb[$];
    logic [65:0] got_a[$];
    logic [67:0] got_b[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference record for the default parameters (align 2, EX_ADDR 16, HOLE 10).
    function automatic logic [65:0] model(input int c);
        logic [31:0] cv, a;
        logic        ex, v;
        cv = 32'(c);
        a  = {cv[31:2], 2'b00};
        ex = (a == 32'd0) || (a == 32'd16);
        v  = !ex && (cv != 32'd10);
        return {ex, v, (v ? cv : 32'd0), a};
    endfunction

    task automatic push_a();
        qa.delete();
        got_a.delete();
        for (int c = 0; c < 20; c++) qa.push_back(model(c));
    endtask

    task automatic push_b();
        qb.delete();
        got_b.delete();
        for (int k = 0; k < 20; k++)
            for (int ch = 0; ch < 3; ch++)
                qb.push_back({2'(ch), model(ch*100 + k)});
    endtask

    task automatic cyc_a(input logic ack, output logic hs);
        logic [65:0] e;
        @(negedge clk);
        ifa.m_ack = ack;
        #1;
        hs = ifa.m_stb && ack;
        if (hs) begin
            checks++;
            assert (qa.size() != 0) else begin
                failures++;
                $error("FAIL a_extra_hs observed=%0h expected=none", ifa.m_req);
            end
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_req", ifa.m_req, e);
                check("a_chan", ifa.m_chan, 0);
                got_a.push_back(ifa.m_req);
            end
        end
    endtask

    task automatic cyc_b(input logic ack, output logic hs);
        logic [67:0] e;
        @(negedge clk);
        ifb.m_ack = ack;
        #1;
        hs = ifb.m_stb && ack;
        if (hs) begin
            checks++;
            assert (qb.size() != 0) else begin
                failures++;
                $error("FAIL b_extra_hs observed=%0h expected=none", ifb.m_req);
            end
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_req", ifb.m_req, e[65:0]);
                check("b_chan", ifb.m_chan, e[67:66]);
                got_b.push_back({ifb.m_chan, ifb.m_req});
            end
        end
    endtask

    initial begin
        logic        hs;
        int          n, iters;
        logic [65:0] held;
        logic [1:0]  heldc;

        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.m_ack = 1'b0;
        ifb.m_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("a_rst_stb", ifa.m_stb, 0);
        check("a_rst_req", ifa.m_req, 0);
        check("a_rst_chan", ifa.m_chan, 0);
        check("a_rst_done", done_a, 0);
        check("b_rst_stb", ifb.m_stb, 0);
        check("b_rst_req", ifb.m_req, 0);
        check("b_rst_chan", ifb.m_chan, 0);
        check("b_rst_done", done_b, 0);

        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        push_a();
        push_b();

        // Edge 1 fills slots only; first record appears after edge 2.
        cyc_a(1'b1, hs);
        check("a_stb_edge1", ifa.m_stb, 0);
        iters = 0;
        for (int i = 0; i < 200 && qa.size() != 0; i++) begin
            cyc_a(1'b1, hs);
            iters++;
        end
        check("a_drain", qa.size(), 0);
        check("a_throughput_cycles", iters, 20);
        check("a_done_low_before", done_a, 0);
        cyc_a(1'b1, hs);
        check("a_done_rise", done_a, 1);
        check("a_stb_cleared", ifa.m_stb, 0);
        if (got_a.size() == 20) begin
            check("a_c0", got_a[0], 66'h2_0000_0000_0000_0000);
            check("a_c3", got_a[3], 66'h2_0000_0000_0000_0000);
            check("a_c5", got_a[5], 66'h1_0000_0005_0000_0004);
            check("a_c10", got_a[10], 66'h0_0000_0000_0000_0008);
            check("a_c15", got_a[15], 66'h1_0000_000F_0000_000C);
            check("a_c17", got_a[17], 66'h2_0000_0000_0000_0010);
        end
`ifdef SPLIT_REQ_GEN_STATS_EN
        check("a_stat_ex", sxa[0], 8);
        check("a_stat_inv", sia[0], 1);
`endif
        repeat (3) cyc_a(1'b1, hs);
        check("a_done_sticky", done_a, 1);

        // Restart, then reset mid-stream.
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("a_done_cleared", done_a, 0);
        @(negedge clk);
        rst_a = 1'b1;
        push_a();
        for (int i = 0; i < 8; i++) cyc_a(1'b1, hs);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("a_mid_rst_stb", ifa.m_stb, 0);
        check("a_mid_rst_req", ifa.m_req, 0);
        check("a_mid_rst_chan", ifa.m_chan, 0);
        @(negedge clk);
        rst_a = 1'b1;
        push_a();
        for (int i = 0; i < 200 && qa.size() != 0; i++) cyc_a(1'b1, hs);
        check("a2_drain", qa.size(), 0);
        if (got_a.size() != 0) check("a2_first_rec", got_a[0], 66'h2_0000_0000_0000_0000);
        cyc_a(1'b0, hs);
        check("a2_done", done_a, 1);

        // Channel B has been stalled all along; stream, apply backpressure, then random ack.
        for (int i = 0; i < 10; i++) cyc_b(1'b1, hs);
        cyc_b(1'b0, hs);
        held  = ifb.m_req;
        heldc = ifb.m_chan;
        for (int i = 0; i < 4; i++) begin
            cyc_b(1'b0, hs);
            check("b_hold_stb", ifb.m_stb, 1);
            check("b_hold_req", ifb.m_req, held);
            check("b_hold_chan", ifb.m_chan, heldc);
        end
        check("b_done_low_mid", done_b, 0);
        for (int i = 0; i < 2000 && qb.size() != 0; i++)
            cyc_b(1'($urandom_range(1, 0)), hs);
        check("b_drain", qb.size(), 0);
        check("b_hs_count", got_b.size(), 60);
        if (got_b.size() > 2) begin
            check("b_ch1_first", got_b[1], {2'd1, 66'h1_0000_0064_0000_0064});
            check("b_ch2_first", got_b[2], {2'd2, 66'h1_0000_00C8_0000_00C8});
        end
        cyc_b(1'b1, hs);
        check("b_done_rise", done_b, 1);
        repeat (3) cyc_b(1'b1, hs);
        check("b_done_sticky", done_b, 1);
        check("b_stb_idle", ifb.m_stb, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/split_req_gen.md
# split_req_gen

Parametrised multi-channel request generator and merger for struct-splitting regression designs. Each of N channels derives a packed request record (ex, valid, payload{data, addr}) from its own counter. Each channel buffers one record. A round-robin arbiter merges the channels onto one registered output with a strobe/acknowledge handshake. The block sits in front of a checker that consumes one record per handshake.

## Interface
- NUM_CH, 2: number of channels, 1..8
- DATA_W, 32: counter, data and address width
- ALIGN_LOG2, 2: number of address low bits forced to zero
- EX_ADDR, 16: second aligned address that raises ex (address 0 always raises ex)
- HOLE, 10: counter value that forces valid=0
- LIMIT, 20: records generated per channel, at least 1
- STRIDE, 0: start counter of channel i is i*STRIDE
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_stb  out  1  output record present
- m_ack  in  1  consumer accepts the record; a handshake occurs when m_stb && m_ack
- m_req  out  2+2*DATA_W  {ex, valid, data, addr}, packed in that order with MSB first
- m_chan  out  $clog2(NUM_CH) (min 1)  source channel of m_req
- done  out  1  all channels exhausted and output drained

## Operation
Record rule, for counter c, with all arithmetic mod 2^DATA_W:
- addr = c with bits [ALIGN_LOG2-1:0] cleared.
- ex = (addr == 0) || (addr == EX_ADDR).
- valid = !ex && (c != HOLE).
- data = valid ? c : 0.

Per channel:
- Counter cnt, reset value i*STRIDE. Generated-record count gen, reset value 0.
- Slot holds one record; slot_full resets to 0.
- When the slot is empty or granted this cycle, and gen < LIMIT: load the record for cnt, set cnt = cnt+1 and gen = gen+1.
- Channel is exhausted when gen == LIMIT and the slot is empty.
- The record's valid field is payload metadata only. It never gates the handshake. Records with ex=1 or valid=0 are still emitted.

Merge:
- Output register m_req/m_chan/m_stb loads when m_stb==0 or a handshake occurs this cycle.
- Loaded from the granted full slot; if no slot is full, m_stb clears.
- Round-robin pointer resets to 0. It searches channels ptr, ptr+1, … mod NUM_CH.
- After a grant to channel g, ptr = (g+1) mod NUM_CH. With no grant, ptr holds.
- A slot granted and refilled in the same cycle is legal: one record leaves and a new one enters.
- done = all channels exhausted && m_stb==0. Once high, done stays high until reset.

## Timing
- Reset: m_stb=0, m_req=0, m_chan=0, done=0, ptr=0, all slots empty, counters at start values.
- Edge 1 after reset release: slots load their first records.
- Edge 2: m_stb=1 with channel 0's first record.
- Sustained throughput: one record per cycle when m_ack is held high.
- While m_stb && !m_ack: m_req and m_chan are held bit-stable. No record is lost or duplicated.
- Slot refill happens in the grant cycle, so a single channel with m_ack=1 emits on consecutive cycles.
- Reset asserted mid-stream: all state clears immediately, asynchronously. Generation restarts from the start values.

## Configuration
- SPLIT_REQ_GEN_STATS_EN defined: adds outputs stat_ex[NUM_CH][16] and stat_inv[NUM_CH][16].
  - stat_ex counts handshaked records with ex=1; stat_inv counts those with valid=0 && ex=0.
  - Both count per channel, reset to 0 and saturate at 16'hFFFF.
- SPLIT_REQ_GEN_STATS_EN undefined: the ports and counters do not exist.

## Structure
- Package split_req_pkg:
  - REQ_EX_BIT and REQ_VALID_BIT offset functions of DATA_W.
  - Function req_make(c, ALIGN_LOG2, EX_ADDR, HOLE) returning the packed record.
  - Default typedefs data_t, addr_t, payload_t and req_t for DATA_W=32.
- Sub-module split_req_chan: counter, gen count and slot for one channel. Inputs: grant. Outputs: slot_full, slot_req, exhausted.
- The arbiter and output register stay in the top module.

## Test plan
- NUM_CH=1 with defaults, m_ack=1:
  - counters 0..3: ex=1, valid=0.
  - counters 4..15 except 10: valid=1, ex=0, addr=(c>>2)<<2, data=c.
  - counter 10: valid=0, ex=0, data=0.
  - counters 16..19: ex=1, valid=0, data=0, addr=16.
- NUM_CH=3, STRIDE=100, m_ack=1: m_chan sequence is 0,1,2,0,1,2…; channel 1's first record has addr=100 and data=100. Exactly 60 handshakes occur.
- Backpressure, NUM_CH=2: drop m_ack low for 5 cycles mid-stream. m_req must stay stable, and the per-channel counter sequence must be gap-free after release.
- Random m_ack (50%), NUM_CH=4: each channel delivers exactly LIMIT records in counter order. done rises one cycle after the last handshake and stays high.
- Drop rst_n for 1 cycle mid-stream: outputs are zero during reset, and the first record after release is channel 0 at its start counter.
- With SPLIT_REQ_GEN_STATS_EN, NUM_CH=1 and defaults: at done, stat_ex=8 (counters 0–3 and 16–19) and stat_inv=1 (counter 10).
